// File: rtl/memory_stage.sv
// Memory stage between execute and writeback: latches the execute result, runs one
// load/store handshake at a time against a variable-latency data memory, registers the result.
module memory_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_Xcomp,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_memRead,
  input  logic              ex_memWrite,
  input  logic              ex_regWrite,
  input  logic [2:0]        ex_wrReg,
  input  logic              ex_halt,
  output logic              mem_stall,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rd,
  output logic              dm_wr,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_done,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_regWrite,
  output logic [2:0]        wb_wrReg,
  output logic              halted,
  output logic              err
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              is_load_q;
  logic              regwrite_q;
  logic [2:0]        wrreg_q;
  logic [CntW-1:0]   wait_cnt_q;

  logic accept;
  logic is_mem;

  assign accept    = (state_q == StIdle) & ex_valid & ~halted & ~err;
  assign is_mem    = ex_memRead | ex_memWrite;
  assign mem_stall = (state_q != StIdle);
  assign dm_addr   = addr_q;
  assign dm_wdata  = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_load_q   <= 1'b0;
      regwrite_q  <= 1'b0;
      wrreg_q     <= '0;
      wait_cnt_q  <= '0;
      dm_rd       <= 1'b0;
      dm_wr       <= 1'b0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_regWrite <= 1'b0;
      wb_wrReg    <= '0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      dm_rd    <= 1'b0;
      dm_wr    <= 1'b0;
      wb_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q     <= ex_Xcomp;
            wdata_q    <= ex_wdata;
            regwrite_q <= ex_regWrite;
            wrreg_q    <= ex_wrReg;
            is_load_q  <= ex_memRead;
            if (ex_halt) begin
              halted      <= 1'b1;
              wb_valid    <= 1'b1;
              wb_data     <= ex_Xcomp;
              wb_regWrite <= 1'b0;
              wb_wrReg    <= ex_wrReg;
            end else if (!is_mem) begin
              wb_valid    <= 1'b1;
              wb_data     <= ex_Xcomp;
              wb_regWrite <= ex_regWrite;
              wb_wrReg    <= ex_wrReg;
            end else if (ex_Xcomp[0]) begin
              err <= 1'b1;
            end else begin
              // Load and store together is flagged but still runs as a load.
              if (ex_memRead && ex_memWrite) err <= 1'b1;
              dm_rd      <= ex_memRead;
              dm_wr      <= ~ex_memRead;
              wait_cnt_q <= '0;
              state_q    <= StReq;
            end
          end
        end
        StReq, StWait: begin
          if (dm_done) begin
            state_q     <= StIdle;
            wb_valid    <= 1'b1;
            wb_data     <= is_load_q ? dm_rdata : addr_q;
            wb_regWrite <= regwrite_q;
            wb_wrReg    <= wrreg_q;
          end else if (state_q == StReq) begin
            state_q <= StWait;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
            if (wait_cnt_q == CntW'(MAX_WAIT - 1)) begin
              err     <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed scenarios plus randomized ALU/load/store traffic
// against a reference memory model and a variable-latency memory responder.
module tb_memory_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned MW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid, ex_memRead, ex_memWrite, ex_regWrite, ex_halt;
  logic [DW-1:0] ex_Xcomp, ex_wdata;
  logic [2:0]    ex_wrReg;
  logic          mem_stall, dm_rd, dm_wr, dm_done, wb_valid, wb_regWrite, halted, err;
  logic [DW-1:0] dm_addr, dm_wdata, dm_rdata, wb_data;
  logic [2:0]    wb_wrReg;

  always #5 clk = ~clk;

  memory_stage #(.DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_Xcomp(ex_Xcomp), .ex_wdata(ex_wdata),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_regWrite(ex_regWrite),
    .ex_wrReg(ex_wrReg), .ex_halt(ex_halt), .mem_stall(mem_stall), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_regWrite(wb_regWrite), .wb_wrReg(wb_wrReg),
    .halted(halted), .err(err)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        rw;
    logic [2:0]  wrreg;
  } wb_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  wb_t         exp_q[$];
  req_t        req_q[$];
  int          dly_q[$];
  logic [15:0] ref_mem[logic [15:0]];
  logic [15:0] dev_mem[logic [15:0]];

  int  n_vec = 0;
  int  n_err = 0;
  bit  halted_m, err_m;
  int  stall_cnt = 0, rd_cnt = 0, wr_cnt = 0, wb_cnt = 0, wbc;
  time acc_time = 0, wb_time = 0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h3c96;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_stall) stall_cnt++;
      if (dm_rd) rd_cnt++;
      if (dm_wr) wr_cnt++;
    end
  end

  // Monitor: every writeback pulse must match the oldest expected result.
  initial begin
    forever begin : mon
      wb_t e;
      @(negedge clk);
      if (rst_n && wb_valid) begin
        wb_cnt++;
        wb_time = $time;
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 64'(wb_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_fields", 64'({wb_data, wb_regWrite, wb_wrReg}), 64'(e));
        end
      end
    end
  end

  // Memory device: checks each request, then answers after the delay chosen at issue (-1: never).
  initial begin
    dm_done  = 1'b0;
    dm_rdata = '0;
    forever begin : resp
      int          d;
      req_t        r;
      logic [15:0] a;
      @(negedge clk);
      if (rst_n && (dm_rd || dm_wr)) begin
        if (req_q.size() == 0) begin
          check("dm_unexpected", 64'({dm_rd, dm_wr}), 64'd0);
          d = -1;
        end else begin
          r = req_q.pop_front();
          d = dly_q.pop_front();
          check("dm_request", 64'({dm_rd, dm_wr, dm_addr, dm_wdata}), 64'(r));
        end
        a = dm_addr;
        if (dm_wr) dev_mem[a] = dm_wdata;
        if (d >= 0) begin
          repeat (d) @(negedge clk);
          dm_rdata = dev_mem.exists(a) ? dev_mem[a] : init_val(a);
          dm_done  = 1'b1;
          @(negedge clk);
          dm_done  = 1'b0;
          dm_rdata = 16'($urandom);
        end
      end
    end
  end

  // Drive one instruction, hold it while stalled, and record what the stage should produce.
  task automatic issue(input logic [15:0] x, input logic [15:0] wd, input logic rd,
                       input logic wr, input logic rw, input logic [2:0] wr_reg,
                       input logic hlt, input int dly);
    int g = 0;
    ex_Xcomp = x; ex_wdata = wd; ex_memRead = rd; ex_memWrite = wr;
    ex_regWrite = rw; ex_wrReg = wr_reg; ex_halt = hlt; ex_valid = 1'b1;
    while (mem_stall && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) check("stall_bound", 64'(mem_stall), 64'd0);
    if (!halted_m && !err_m) begin
      if (hlt) begin
        exp_q.push_back(wb_t'({x, 1'b0, wr_reg}));
        halted_m = 1'b1;
      end else if (!(rd || wr)) begin
        exp_q.push_back(wb_t'({x, rw, wr_reg}));
      end else if (x[0]) begin
        err_m = 1'b1;
      end else begin
        if (rd && wr) err_m = 1'b1;
        req_q.push_back(req_t'({rd, !rd, x, wd}));
        dly_q.push_back(dly);
        if (dly < 0 || dly > int'(MW)) err_m = 1'b1;
        else exp_q.push_back(wb_t'({rd ? (ref_mem.exists(x) ? ref_mem[x] : init_val(x)) : x,
                                    rw, wr_reg}));
        if (!rd) ref_mem[x] = wd;
      end
    end
    @(posedge clk);
    acc_time = $time;
    @(negedge clk);
    ex_valid = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0; ex_halt = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || mem_stall) && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (g >= 60) check("drain_bound", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", 64'({mem_stall, dm_rd, dm_wr, dm_addr, dm_wdata, wb_valid, wb_data,
                                   wb_regWrite, wb_wrReg, halted, err}), 64'd0);
    exp_q.delete(); req_q.delete(); dly_q.delete();
    halted_m = 1'b0;
    err_m    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic longint lat(input time a, input time w);
    return longint'((w - a + 5) / 10);
  endfunction

  initial begin
    ex_valid = 0; ex_memRead = 0; ex_memWrite = 0; ex_regWrite = 0; ex_halt = 0;
    ex_Xcomp = '0; ex_wdata = '0; ex_wrReg = '0;
    do_reset();

    // ALU result passes straight through in one cycle.
    stall_cnt = 0;
    issue(16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 0);
    drain();
    check("alu_latency", 64'(lat(acc_time, wb_time)), 64'd1);
    check("alu_no_stall", 64'(stall_cnt), 64'd0);

    // Load with three extra memory cycles.
    ref_mem[16'h0040] = 16'hBEEF;
    dev_mem[16'h0040] = 16'hBEEF;
    stall_cnt = 0; rd_cnt = 0;
    issue(16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 3);
    drain();
    check("load_rd_pulse", 64'(rd_cnt), 64'd1);
    check("load_stall_cycles", 64'(stall_cnt), 64'd4);
    check("load_latency", 64'(lat(acc_time, wb_time)), 64'd5);

    // Zero-wait store.
    wr_cnt = 0;
    issue(16'h0010, 16'hA5A5, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 0);
    drain();
    check("store_wr_pulse", 64'(wr_cnt), 64'd1);
    check("store_latency", 64'(lat(acc_time, wb_time)), 64'd2);

    // HALT retires, then everything is ignored.
    issue(16'h7777, 16'h0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 0);
    drain();
    check("halted_set", 64'(halted), 64'd1);
    wbc = wb_cnt;
    issue(16'h4321, 16'h0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("halt_ignores", 64'(wb_cnt - wbc), 64'd0);

    // Misaligned load.
    do_reset();
    rd_cnt = 0;
    wbc = wb_cnt;
    issue(16'h0011, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("misalign_err", 64'(err), 64'd1);
    check("misalign_no_rd", 64'(rd_cnt), 64'd0);
    issue(16'h0abc, 16'h0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("err_ignores", 64'(wb_cnt - wbc), 64'd0);

    // Timeout: memory never answers.
    do_reset();
    stall_cnt = 0;
    issue(16'h0020, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, -1);
    drain();
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_idle", 64'(mem_stall), 64'd0);
    check("timeout_stall_cycles", 64'(stall_cnt), 64'd9);

    // Reset while waiting; the late dm_done must be ignored.
    do_reset();
    issue(16'h0050, 16'h0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 6);
    @(negedge clk);
    wbc = wb_cnt;
    do_reset();
    repeat (10) @(negedge clk);
    check("reset_abandon_wb", 64'(wb_cnt - wbc), 64'd0);
    check("late_done_ignored", 64'(mem_stall), 64'd0);

    // Load and store flags together: runs as a load and flags an error.
    do_reset();
    issue(16'h0030, 16'h1111, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1);
    drain();
    check("both_flags_err", 64'(err), 64'd1);

    // Random traffic over a small aligned address window so loads see earlier stores.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      int unsigned op = $urandom_range(0, 9);
      logic [15:0] a  = 16'($urandom_range(0, 31)) << 1;
      logic [15:0] v  = 16'($urandom);
      logic [2:0]  r  = 3'($urandom);
      logic        w  = 1'($urandom);
      int          d  = int'($urandom_range(0, MW));
      if (op < 4)      issue(v, 16'($urandom), 1'b0, 1'b0, w, r, 1'b0, 0);
      else if (op < 7) issue(a, 16'($urandom), 1'b1, 1'b0, w, r, 1'b0, d);
      else             issue(a, v, 1'b0, 1'b1, w, r, 1'b0, d);
    end
    drain();
    check("random_no_err", 64'(err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
